// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one synchronous single-port BRAM between the CPU instruction-fetch
// requester (i_*) and the load/store data requester (d_*). Every access goes
// through a fixed schedule:
//   IDLE  - requests are sampled and a winner is chosen
//   ISSUE - memory bus driven for one cycle, grant pulse to the winner
//   WAIT  - RD_LAT cycles for a read; rvalid pulses in the last one
// Writes skip WAIT and return to IDLE right after ISSUE.
// Collisions are resolved round-robin against the last granted requester.
// Data wins the first collision after reset.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   i_req/i_addr           fetch request, held until i_gnt
//   i_gnt/i_rvalid/i_rdata fetch issue pulse, data-valid pulse, read data
//   d_req/d_addr/d_we/d_wdata  data request (d_we==0 is a read)
//   d_gnt/d_rvalid/d_rdata data issue pulse, load-valid pulse, load data
//   m_en/m_we/m_addr/m_wdata/m_rdata  BRAM port (m_addr is a word address)
//
// All outputs are registered except i_rdata/d_rdata. Those pass m_rdata
// straight through and are meaningful only while the matching rvalid is high.

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_en,
    output logic [DATA_W/8-1:0] m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int BE_W = DATA_W / 8;

    // Index of the final WAIT cycle. The read data is valid in that cycle.
    localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    // Control state
    state_t              r_state,     w_stateNext;
    grant_t              r_lastGrant, w_lastGrantNext;
    logic [2:0]          r_waitCnt,   w_waitCntNext;
    logic                r_winData,   w_winDataNext;
    logic                r_isWrite,   w_isWriteNext;

    // Registered outputs
    logic                r_mEn,       w_mEnNext;
    logic [BE_W-1:0]     r_mWe,       w_mWeNext;
    logic [ADDR_W-1:0]   r_mAddr,     w_mAddrNext;
    logic [DATA_W-1:0]   r_mWdata,    w_mWdataNext;
    logic                r_iGnt,      w_iGntNext;
    logic                r_dGnt,      w_dGntNext;
    logic                r_iRvalid,   w_iRvalidNext;
    logic                r_dRvalid,   w_dRvalidNext;

    // Arbitration helpers
    logic                w_anyReq;
    logic                w_pickData;
    logic [ADDR_W-1:0]   w_pickAddr;
    logic                w_pickWrite;
    logic                w_unusedAddrBits;

    // Winner selection for the IDLE cycle. A lone requester always wins.
    // On a collision, whoever did not get the previous grant goes next.
    // Since last_grant resets to INST, data takes the first collision.
    assign w_anyReq    = i_req | d_req;
    assign w_pickData  = d_req & (~i_req | (r_lastGrant == GRANT_INST));
    assign w_pickAddr  = w_pickData ? d_addr : i_addr;
    assign w_pickWrite = w_pickData & (d_we != '0);

    // The memory is word addressed, so the byte offset is simply dropped.
    assign w_unusedAddrBits = ^{i_addr[1:0], d_addr[1:0]};

    // Next-state and next-output logic. Every output is computed one cycle
    // ahead and registered, so the bus and the strobes come straight from
    // flops. Address and write data hold their last value between accesses.
    // The enables and strobes fall back to zero.
    always_comb begin
        w_stateNext     = r_state;
        w_lastGrantNext = r_lastGrant;
        w_waitCntNext   = r_waitCnt;
        w_winDataNext   = r_winData;
        w_isWriteNext   = r_isWrite;
        w_mEnNext       = 1'b0;
        w_mWeNext       = '0;
        w_mAddrNext     = r_mAddr;
        w_mWdataNext    = r_mWdata;
        w_iGntNext      = 1'b0;
        w_dGntNext      = 1'b0;
        w_iRvalidNext   = 1'b0;
        w_dRvalidNext   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_stateNext     = ISSUE;
                    w_winDataNext   = w_pickData;
                    w_isWriteNext   = w_pickWrite;
                    w_lastGrantNext = w_pickData ? GRANT_DATA : GRANT_INST;
                    w_mEnNext       = 1'b1;
                    w_mWeNext       = w_pickData ? d_we : '0;
                    w_mAddrNext     = {2'b00, w_pickAddr[ADDR_W-1:2]};
                    w_mWdataNext    = w_pickData ? d_wdata : '0;
                    w_iGntNext      = ~w_pickData;
                    w_dGntNext      = w_pickData;
                end
            end

            ISSUE: begin
                if (r_isWrite) begin
                    w_stateNext = IDLE;
                end else begin
                    // The rvalid strobe is registered, so it is raised on
                    // entry to the last WAIT cycle rather than inside it.
                    w_stateNext   = WAIT;
                    w_waitCntNext = 3'd0;
                    if (LAST_WAIT == 3'd0) begin
                        w_iRvalidNext = ~r_winData;
                        w_dRvalidNext = r_winData;
                    end
                end
            end

            WAIT: begin
                if (r_waitCnt == LAST_WAIT) begin
                    w_stateNext = IDLE;
                end else begin
                    w_waitCntNext = r_waitCnt + 3'd1;
                    if ((r_waitCnt + 3'd1) == LAST_WAIT) begin
                        w_iRvalidNext = ~r_winData;
                        w_dRvalidNext = r_winData;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State and output registers. Reset also discards any read still in
    // flight, because the WAIT state and its pending rvalid are cleared here.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_lastGrant <= GRANT_INST;
            r_waitCnt   <= 3'd0;
            r_winData   <= 1'b0;
            r_isWrite   <= 1'b0;
            r_mEn       <= 1'b0;
            r_mWe       <= '0;
            r_mAddr     <= '0;
            r_mWdata    <= '0;
            r_iGnt      <= 1'b0;
            r_dGnt      <= 1'b0;
            r_iRvalid   <= 1'b0;
            r_dRvalid   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_lastGrant <= w_lastGrantNext;
            r_waitCnt   <= w_waitCntNext;
            r_winData   <= w_winDataNext;
            r_isWrite   <= w_isWriteNext;
            r_mEn       <= w_mEnNext;
            r_mWe       <= w_mWeNext;
            r_mAddr     <= w_mAddrNext;
            r_mWdata    <= w_mWdataNext;
            r_iGnt      <= w_iGntNext;
            r_dGnt      <= w_dGntNext;
            r_iRvalid   <= w_iRvalidNext;
            r_dRvalid   <= w_dRvalidNext;
        end
    end

    assign m_en     = r_mEn;
    assign m_we     = r_mWe;
    assign m_addr   = r_mAddr;
    assign m_wdata  = r_mWdata;
    assign i_gnt    = r_iGnt;
    assign d_gnt    = r_dGnt;
    assign i_rvalid = r_iRvalid;
    assign d_rvalid = r_dRvalid;

    // Read data goes to both requesters. Only the rvalid says whose it is.
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (RD_LAT = 3).
// A behavioural BRAM sits on the memory port. Two requester drivers work
// from pending-transaction queues. At each sampling point a transaction-level
// reference model decides which requester the arbiter must serve. It then
// predicts the grant cycle, the memory-bus contents and the read-data cycle
// and value, and pushes them into scoreboard queues. A separate monitor pops
// and compares them against the DUT every cycle.

module tb_mem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 3;
    localparam int MEM_WORDS = 64;

    logic        aclk;
    logic        aresetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    typedef struct {
        int          cycle;
        bit          isData;
        logic [31:0] wordAddr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } grantExp_t;

    typedef struct {
        int          cycle;
        bit          isData;
        logic [31:0] data;
    } rvExp_t;

    txn_t        iPend[$];
    txn_t        dPend[$];
    grantExp_t   grantQ[$];
    rvExp_t      rvQ[$];

    logic [31:0] bramMem [MEM_WORDS];
    logic [31:0] refMem  [MEM_WORDS];
    logic [31:0] rdPipe  [RD_LAT];
    logic        memLoad;

    int          cycle = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          freeAt = 0;
    bit          lastData = 0;
    bit          checking = 0;
    bit          logGrants = 0;
    string       grantLog = "";
    logic [31:0] lastDRdata = '0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Cycle index shared by the reference model and the monitor.
    always @(posedge aclk) cycle <= cycle + 1;

    function automatic logic [31:0] initWord(input int i);
        return {8'(i), 8'hC3, 8'(i * 7), 8'h5A};
    endfunction

    // Behavioural BRAM with RD_LAT cycles of read latency and byte writes.
    always @(posedge aclk) begin
        if (memLoad) begin
            for (int i = 0; i < MEM_WORDS; i++) bramMem[i] <= initWord(i);
            for (int k = 0; k < RD_LAT; k++) rdPipe[k] <= '0;
        end else begin
            if (m_en) begin
                rdPipe[0] <= bramMem[m_addr[5:0]];
                for (int b = 0; b < 4; b++)
                    if (m_we[b]) bramMem[m_addr[5:0]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
            for (int k = 1; k < RD_LAT; k++) rdPipe[k] <= rdPipe[k-1];
        end
    end
    assign m_rdata = rdPipe[RD_LAT-1];

    // Fetch requester: holds its request until granted, then moves on.
    initial begin
        txn_t t;
        i_req  = 1'b0;
        i_addr = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (i_req && i_gnt) i_req = 1'b0;
            if (!i_req && iPend.size() > 0) begin
                if (iPend[0].gap > 0) iPend[0].gap = iPend[0].gap - 1;
                else begin
                    t      = iPend.pop_front();
                    i_addr = t.addr;
                    i_req  = 1'b1;
                end
            end
        end
    end

    // Load/store requester.
    initial begin
        txn_t t;
        d_req   = 1'b0;
        d_addr  = '0;
        d_we    = '0;
        d_wdata = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (d_req && d_gnt) d_req = 1'b0;
            if (!d_req && dPend.size() > 0) begin
                if (dPend[0].gap > 0) dPend[0].gap = dPend[0].gap - 1;
                else begin
                    t       = dPend.pop_front();
                    d_addr  = t.addr;
                    d_we    = t.we;
                    d_wdata = t.wdata;
                    d_req   = 1'b1;
                end
            end
        end
    end

    // Reference model at transaction level. When the port is free it serves
    // one requester, chosen round-robin. The result shows up one cycle later
    // on the bus. A read returns RD_LAT cycles after that. The port is free
    // again two cycles after sampling for a write, or RD_LAT+2 for a read.
    always @(negedge aclk) begin : refModel
        grantExp_t   g;
        rvExp_t      r;
        grantExp_t   keepG[$];
        rvExp_t      keepR[$];
        bit          pickData;
        logic [31:0] addr;
        logic [5:0]  idx;
        if (!aresetn) begin
            keepG = {};
            keepR = {};
            foreach (grantQ[k]) if (grantQ[k].cycle <= cycle) keepG.push_back(grantQ[k]);
            foreach (rvQ[k])    if (rvQ[k].cycle <= cycle)    keepR.push_back(rvQ[k]);
            grantQ   = keepG;
            rvQ      = keepR;
            freeAt   = cycle + 1;
            lastData = 1'b0;
        end else if (cycle >= freeAt && (i_req || d_req)) begin
            pickData = d_req && (!i_req || !lastData);
            lastData = pickData;
            addr     = pickData ? d_addr : i_addr;
            g.cycle    = cycle + 1;
            g.isData   = pickData;
            g.wordAddr = addr >> 2;
            g.we       = pickData ? d_we : 4'h0;
            g.wdata    = pickData ? d_wdata : 32'h0;
            grantQ.push_back(g);
            idx = addr[7:2];
            if (g.we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (g.we[b]) refMem[idx][8*b +: 8] = g.wdata[8*b +: 8];
                freeAt = cycle + 2;
            end else begin
                r.cycle  = cycle + 1 + RD_LAT;
                r.isData = pickData;
                r.data   = refMem[idx];
                rvQ.push_back(r);
                freeAt = cycle + 2 + RD_LAT;
            end
        end
    end

    // Monitor: every cycle, compare the bus and the rvalid strobes against
    // whatever the scoreboard holds for this cycle. Idle is also expected.
    always @(negedge aclk) begin : monitor
        grantExp_t   g;
        rvExp_t      r;
        logic        expEn, expI, expD, expIv, expDv;
        logic [3:0]  expWe;
        logic [31:0] expAddr, expWdata, expData;
        if (checking) begin
            while (grantQ.size() > 0 && grantQ[0].cycle < cycle) begin
                g = grantQ.pop_front();
                compared++; mismatched++;
                $display("[TB] FAIL missedGrant cycle %0d: got nothing, want grant isData=%0b", g.cycle, g.isData);
            end
            while (rvQ.size() > 0 && rvQ[0].cycle < cycle) begin
                r = rvQ.pop_front();
                compared++; mismatched++;
                $display("[TB] FAIL missedRvalid cycle %0d: got nothing, want rvalid isData=%0b", r.cycle, r.isData);
            end

            expEn = 0; expI = 0; expD = 0; expWe = '0; expAddr = '0; expWdata = '0;
            if (grantQ.size() > 0 && grantQ[0].cycle == cycle) begin
                g = grantQ.pop_front();
                expEn = 1; expI = !g.isData; expD = g.isData;
                expWe = g.we; expAddr = g.wordAddr; expWdata = g.wdata;
            end
            compared++;
            if ({m_en, i_gnt, d_gnt, m_we} !== {expEn, expI, expD, expWe}) begin
                mismatched++;
                $display("[TB] FAIL busCtrl cycle %0d: got en=%b ig=%b dg=%b we=%h, want en=%b ig=%b dg=%b we=%h",
                         cycle, m_en, i_gnt, d_gnt, m_we, expEn, expI, expD, expWe);
            end
            if (expEn) begin
                compared++;
                if (m_addr !== expAddr) begin
                    mismatched++;
                    $display("[TB] FAIL busAddr cycle %0d: got %h, want %h", cycle, m_addr, expAddr);
                end
                if (expWe != 4'h0) begin
                    compared++;
                    if (m_wdata !== expWdata) begin
                        mismatched++;
                        $display("[TB] FAIL busWdata cycle %0d: got %h, want %h", cycle, m_wdata, expWdata);
                    end
                end
            end

            expIv = 0; expDv = 0; expData = '0;
            if (rvQ.size() > 0 && rvQ[0].cycle == cycle) begin
                r = rvQ.pop_front();
                expIv = !r.isData; expDv = r.isData; expData = r.data;
            end
            compared++;
            if ({i_rvalid, d_rvalid} !== {expIv, expDv}) begin
                mismatched++;
                $display("[TB] FAIL rvalid cycle %0d: got i=%b d=%b, want i=%b d=%b",
                         cycle, i_rvalid, d_rvalid, expIv, expDv);
            end
            if (expIv) begin
                compared++;
                if (i_rdata !== expData) begin
                    mismatched++;
                    $display("[TB] FAIL iRdata cycle %0d: got %h, want %h", cycle, i_rdata, expData);
                end
            end
            if (expDv) begin
                compared++;
                if (d_rdata !== expData) begin
                    mismatched++;
                    $display("[TB] FAIL dRdata cycle %0d: got %h, want %h", cycle, d_rdata, expData);
                end
            end

            if (d_rvalid) lastDRdata = d_rdata;
            if (logGrants) begin
                if (d_gnt) grantLog = {grantLog, "D"};
                if (i_gnt) grantLog = {grantLog, "I"};
            end
        end
    end

    task automatic applyStimulus(input bit isData, input logic [31:0] addr,
                                 input logic [3:0] we, input logic [31:0] wdata,
                                 input int gap);
        txn_t t;
        t.addr  = addr;
        t.we    = we;
        t.wdata = wdata;
        t.gap   = gap;
        if (isData) dPend.push_back(t);
        else        iPend.push_back(t);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".m_en"},     32'(m_en),     32'h0);
        checkOutput({tag, ".m_we"},     32'(m_we),     32'h0);
        checkOutput({tag, ".m_addr"},   m_addr,        32'h0);
        checkOutput({tag, ".m_wdata"},  m_wdata,       32'h0);
        checkOutput({tag, ".i_gnt"},    32'(i_gnt),    32'h0);
        checkOutput({tag, ".d_gnt"},    32'(d_gnt),    32'h0);
        checkOutput({tag, ".i_rvalid"}, 32'(i_rvalid), 32'h0);
        checkOutput({tag, ".d_rvalid"}, 32'(d_rvalid), 32'h0);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while (!(iPend.size() == 0 && dPend.size() == 0 && !i_req && !d_req &&
                 grantQ.size() == 0 && rvQ.size() == 0)) begin
            @(negedge aclk);
            n++;
            if (n > budget) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s timeout: got still busy after %0d cycles, want idle", name, budget);
                return;
            end
        end
    endtask

    initial begin
        logic [31:0] partialExp;
        bit          gotGnt;

        aresetn = 1'b0;
        memLoad = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initWord(i);
        repeat (3) @(posedge aclk);
        #1;
        memLoad  = 1'b0;
        aresetn  = 1'b1;
        checking = 1'b1;
        checkResetOutputs("reset");

        // Collision straight after reset: grant order must be D, I, D, I.
        @(negedge aclk);
        logGrants = 1'b1;
        grantLog  = "";
        applyStimulus(1, 32'h0000_0100, 4'h0, 32'h0, 0);
        applyStimulus(0, 32'h0000_0200, 4'h0, 32'h0, 0);
        applyStimulus(1, 32'h0000_0104, 4'hF, 32'h1234_5678, 0);
        applyStimulus(0, 32'h0000_0204, 4'h0, 32'h0, 0);
        waitIdle(200, "collision");
        logGrants = 1'b0;
        compared++;
        if (grantLog != "DIDI") begin
            mismatched++;
            $display("[TB] FAIL grantOrder: got %s, want DIDI", grantLog);
        end

        // Single fetch.
        @(negedge aclk);
        applyStimulus(0, 32'h0000_0010, 4'h0, 32'h0, 0);
        waitIdle(100, "singleFetch");

        // Store then load at 0x20.
        @(negedge aclk);
        applyStimulus(1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 0);
        applyStimulus(1, 32'h0000_0020, 4'h0, 32'h0, 0);
        waitIdle(100, "storeLoad");
        checkOutput("storeLoad.data", lastDRdata, 32'hDEAD_BEEF);

        // Partial write: only byte 1 of word 0xC changes.
        @(negedge aclk);
        applyStimulus(1, 32'h0000_0030, 4'h2, 32'h0000_AB00, 0);
        applyStimulus(1, 32'h0000_0030, 4'h0, 32'h0, 0);
        waitIdle(100, "partialWrite");
        partialExp = initWord(12);
        partialExp[15:8] = 8'hAB;
        checkOutput("partialWrite.data", lastDRdata, partialExp);

        // Reset during WAIT: the outstanding read must be dropped.
        @(negedge aclk);
        applyStimulus(1, 32'h0000_0040, 4'h0, 32'h0, 0);
        gotGnt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge aclk);
            #1;
            if (d_gnt) begin
                gotGnt = 1'b1;
                break;
            end
        end
        checkOutput("resetInWait.dGnt", 32'(gotGnt), 32'h1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        checkResetOutputs("resetInWait");
        repeat (RD_LAT + 3) @(negedge aclk);

        // Fresh traffic after the reset is served normally.
        applyStimulus(0, 32'h0000_0044, 4'h0, 32'h0, 0);
        applyStimulus(1, 32'h0000_0020, 4'h0, 32'h0, 0);
        waitIdle(100, "afterReset");
        checkOutput("afterReset.data", lastDRdata, 32'hDEAD_BEEF);

        // Randomised mixed traffic from both requesters.
        @(negedge aclk);
        for (int n = 0; n < 120; n++) begin
            applyStimulus(0, $urandom, 4'h0, 32'h0, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0)
                applyStimulus(1, $urandom, 4'h0, $urandom, int'($urandom_range(0, 3)));
            else
                applyStimulus(1, $urandom, 4'($urandom_range(1, 15)), $urandom,
                              int'($urandom_range(0, 3)));
        end
        waitIdle(6000, "random");

        repeat (3) @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
